// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding, MMIO map and latency bound for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] MMIO_TOHOST_ADDR = 32'h8000_0000;
  localparam logic [31:0] MMIO_CYCLE_ADDR  = 32'h8000_0004;

  localparam int WAIT_CYCLES_MAX = 15;
  localparam int CNT_W           = $clog2(WAIT_CYCLES_MAX + 1);

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous word array with byte-lane write enables
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [3:0]                     wstrb_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents are deliberately never reset; rdata only moves on an enabled read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed response latency
// Define DMEM_RESPONDER_MMIO_EN to add the tohost register and free-running cycle counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
`ifdef DMEM_RESPONDER_MMIO_EN
  output logic [31:0] tohost,
  output logic        tohost_valid,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic             err_q, sel_sram_q;
  logic [31:0]      rdata_q, sram_rdata, mmio_rdata;

  logic             accept, enter_resp, cur_we, in_ram, hit_tohost, hit_cycle, err_d;
  logic [31:0]      cur_addr, cur_wdata;
  logic [3:0]       cur_wstrb;

  assign accept    = (state_q == S_IDLE) && req_valid;
  // With zero wait states RESP is entered on the accepting edge, so decode the live request there.
  assign cur_we    = accept ? req_we    : we_q;
  assign cur_addr  = accept ? req_addr  : addr_q;
  assign cur_wdata = accept ? req_wdata : wdata_q;
  assign cur_wstrb = accept ? req_wstrb : wstrb_q;

  assign enter_resp = (WAIT_CYCLES == 0) ? accept : ((state_q == S_WAIT) && (cnt_q == '0));

  assign in_ram = (cur_addr >> (AW + 2)) == 32'd0;
  assign err_d  = (cur_addr[1:0] != 2'b00) || !(in_ram || hit_tohost || hit_cycle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_q      <= 1'b0;
      sel_sram_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            sel_sram_q <= 1'b0;
            rdata_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (enter_resp) begin
        err_q      <= err_d;
        sel_sram_q <= !err_d && !cur_we && in_ram;
        rdata_q    <= (!err_d && !cur_we && !in_ram) ? mmio_rdata : '0;
      end
    end
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .en_i    (enter_resp && in_ram && !err_d),
    .we_i    (cur_we),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_wstrb),
    .rdata_o (sram_rdata)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] tohost_q, cycle_q;
  logic        tohost_valid_q;

  assign hit_tohost = (cur_addr == MMIO_TOHOST_ADDR);
  assign hit_cycle  = (cur_addr == MMIO_CYCLE_ADDR) && !cur_we;
  assign mmio_rdata = hit_tohost ? tohost_q : cycle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_q       <= '0;
      cycle_q        <= '0;
      tohost_valid_q <= 1'b0;
    end else begin
      cycle_q        <= cycle_q + 32'd1;
      tohost_valid_q <= enter_resp && hit_tohost && cur_we && !err_d;
      if (enter_resp && hit_tohost && cur_we && !err_d)
        tohost_q <= merge_wstrb(tohost_q, cur_wdata, cur_wstrb);
    end
  end

  assign tohost       = tohost_q;
  assign tohost_valid = tohost_valid_q;
`else
  assign hit_tohost = 1'b0;
  assign hit_cycle  = 1'b0;
  assign mmio_rdata = '0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = sel_sram_q ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder (DEPTH 1024, WAIT 2)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] tohost;
  logic        tohost_valid;
  int          tv_cnt = 0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
`ifdef DMEM_RESPONDER_MMIO_EN
    .tohost       (tohost),
    .tohost_valid (tohost_valid),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  always @(negedge clk) if (tohost_valid) tv_cnt++;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: present, wait for response, handshake immediately.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                        output int lat, output int acc_cyc);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    acc_cyc = cyc;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 20 cycles");
    end else begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd, c1;
    logic        er;
    int          lat, acc, acc1;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_1000, 32'h9999_9999, 4'hF, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1111_1111, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
`ifdef DMEM_RESPONDER_MMIO_EN
    chk("rst_tohost", tohost, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat, acc);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Stalled response: a competing request must be ignored until after the handshake.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd3);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDE22_BE44);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, acc);
    chk("bp_ignored_write", rd, 32'hDE22_BE44);

    // Reset while a write sits in WAIT: the write must never land.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAD0_BAD0; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, acc);
    chk("midrst_old_value", rd, 32'hCAFE_F00D);
    chk("midrst_err", 32'(er), 32'd0);

`ifdef DMEM_RESPONDER_MMIO_EN
    tv_cnt = 0;
    do_req(1'b1, 32'h8000_0000, 32'h1, 4'hF, rd, er, lat, acc);
    chk("tohost_wr_err", 32'(er), 32'd0);
    repeat (3) @(negedge clk);
    chk("tohost_value", tohost, 32'd1);
    chk("tohost_pulse_cycles", 32'(tv_cnt), 32'd1);
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat, acc);
    chk("tohost_rd", rd, 32'd1);
    do_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat, acc1);
    c1 = rd;
    repeat (7) @(negedge clk);
    do_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat, acc);
    chk("cycle_delta", rd - c1, 32'(acc - acc1));
    chk("cycle_err", 32'(er), 32'd0);
`else
    do_req(1'b1, 32'h8000_0000, 32'h1, 4'hF, rd, er, lat, acc);
    chk("nommio_tohost_err", 32'(er), 32'd1);
    chk("nommio_tohost_rdata", rd, 32'd0);
    do_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat, acc);
    chk("nommio_cycle_err", 32'(er), 32'd1);
    chk("nommio_cycle_latency", 32'(lat), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
